// File: rtl/attempt_sequencer_if.sv
// Signal bundle for attempt_sequencer: keypad pulses, comparator handshake,
// entry-buffer write port and status outputs.
// master = keypad front end / comparator / top level, slave = attempt_sequencer.
interface attempt_sequencer_if #(
  parameter int MAX_LEN = 8
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  // Keypad side
  logic              digit_valid;
  logic [3:0]        digit;
  logic              confirm;
  logic              clear;
  // Comparator handshake
  logic              cmp_req;
  logic              cmp_ack;
  logic              cmp_match;
  // Entry-buffer write port
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [3:0]        buf_wdata;
  // Status
  logic [LEN_W-1:0]  entry_len;
  logic              unlock;
  logic              unlocked;
  logic              locked_out;
  logic [3:0]        err_cnt;
  logic [2:0]        state;

  modport master (
    output digit_valid, digit, confirm, clear, cmp_ack, cmp_match,
    input  cmp_req, buf_we, buf_addr, buf_wdata, entry_len,
           unlock, unlocked, locked_out, err_cnt, state
  );

  modport slave (
    input  digit_valid, digit, confirm, clear, cmp_ack, cmp_match,
    output cmp_req, buf_we, buf_addr, buf_wdata, entry_len,
           unlock, unlocked, locked_out, err_cnt, state
  );
endinterface

// File: rtl/attempt_sequencer.sv
// attempt_sequencer: runs one unlock attempt on the doorlock datapath.
// Collects digits into the entry buffer, requests a compare, opens the
// unlock window on a match, and counts consecutive failures into a timed
// lockout. All outputs are registered.
// Optional build macro: ENTRY_TIMEOUT_EN -- discards an entry that sees no
// digit/confirm/clear for TIMEOUT_CYC cycles.
module attempt_sequencer #(
  parameter int MAX_LEN     = 8,
  parameter int MAX_ERR     = 5,
  parameter int LOCKOUT_CYC = 1000,
  parameter int GRANT_CYC   = 500,
  parameter int TIMEOUT_CYC = 2000
) (
  input logic                clk,
  input logic                rst,
  attempt_sequencer_if.slave bus
);

  localparam int ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  // One down-counter serves the grant window, the lockout and the entry
  // timeout; it is sized for the longest of them so it can never wrap.
  localparam int TMR_MAX_A = (GRANT_CYC > LOCKOUT_CYC) ? GRANT_CYC : LOCKOUT_CYC;
  localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYC) ? TMR_MAX_A : TIMEOUT_CYC;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  // Timer holds "cycles remaining minus one"; the phase ends when it reads 0.
  localparam logic [TMR_W-1:0] GRANT_LOAD   = TMR_W'(GRANT_CYC - 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);
`ifdef ENTRY_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_COMPARE = 3'd2,
    S_GRANT   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e            state_q,      state_d;
  logic [LEN_W-1:0]  entry_len_q,  entry_len_d;
  logic              ovf_q,        ovf_d;
  logic              buf_we_q,     buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q,   buf_addr_d;
  logic [3:0]        buf_wdata_q,  buf_wdata_d;
  logic              cmp_req_q,    cmp_req_d;
  logic              unlock_q,     unlock_d;
  logic              unlocked_q,   unlocked_d;
  logic              locked_out_q, locked_out_d;
  logic [3:0]        err_cnt_q,    err_cnt_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;

  logic              digit_ok;
  logic [3:0]        err_inc;

  // Next-state and registered-output computation for the attempt sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d      = state_q;
    entry_len_d  = entry_len_q;
    ovf_d        = ovf_q;
    buf_we_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    cmp_req_d    = cmp_req_q;
    unlock_d     = 1'b0;
    unlocked_d   = unlocked_q;
    locked_out_d = locked_out_q;
    err_cnt_d    = err_cnt_q;
    timer_d      = timer_q;

    // Digits 10..15 are keypad noise and never enter the buffer.
    digit_ok = bus.digit_valid && (bus.digit <= 4'd9);
    // Failure count saturates at 15.
    err_inc  = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;

    unique case (state_q)
      S_IDLE: begin
        // clear and confirm outrank a digit; with an empty entry both are no-ops.
        if (digit_ok && !bus.clear && !bus.confirm) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = '0;
          buf_wdata_d = bus.digit;
          entry_len_d = LEN_W'(1);
          state_d     = S_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
          timer_d     = TIMEOUT_LOAD;
`endif
        end
      end

      S_ENTRY: begin
        if (bus.clear) begin
          entry_len_d = '0;
          ovf_d       = 1'b0;
          state_d     = S_IDLE;
        end else if (bus.confirm) begin
          cmp_req_d = 1'b1;
          state_d   = S_COMPARE;
        end else if (bus.digit_valid) begin
          if (digit_ok) begin
            if (int'(entry_len_q) < MAX_LEN) begin
              buf_we_d    = 1'b1;
              buf_addr_d  = entry_len_q[ADDR_W-1:0];
              buf_wdata_d = bus.digit;
              entry_len_d = entry_len_q + LEN_W'(1);
            end else begin
              // Buffer full: digit is lost, so the attempt must fail.
              ovf_d = 1'b1;
            end
          end
`ifdef ENTRY_TIMEOUT_EN
          timer_d = TIMEOUT_LOAD;
`endif
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (timer_q == '0) begin
          // Abandoned entry: discard quietly, not counted as a failure.
          entry_len_d = '0;
          ovf_d       = 1'b0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
`endif
      end

      S_COMPARE: begin
        // Request stays up until the ack is sampled; keypad is ignored here.
        if (bus.cmp_ack) begin
          cmp_req_d   = 1'b0;
          entry_len_d = '0;
          ovf_d       = 1'b0;
          if (bus.cmp_match && !ovf_q) begin
            unlock_d   = 1'b1;
            unlocked_d = 1'b1;
            err_cnt_d  = 4'd0;
            timer_d    = GRANT_LOAD;
            state_d    = S_GRANT;
          end else begin
            err_cnt_d = err_inc;
            if (int'(err_inc) >= MAX_ERR) begin
              locked_out_d = 1'b1;
              timer_d      = LOCKOUT_LOAD;
              state_d      = S_LOCKOUT;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_GRANT: begin
        // Window closes on expiry or early on confirm.
        if (bus.confirm || (timer_q == '0)) begin
          unlocked_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        // All inputs ignored; the failure history is forgiven on exit.
        if (timer_q == '0) begin
          locked_out_d = 1'b0;
          err_cnt_d    = 4'd0;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      entry_len_q  <= '0;
      ovf_q        <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      cmp_req_q    <= 1'b0;
      unlock_q     <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      err_cnt_q    <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      entry_len_q  <= entry_len_d;
      ovf_q        <= ovf_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      cmp_req_q    <= cmp_req_d;
      unlock_q     <= unlock_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      err_cnt_q    <= err_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.entry_len  = entry_len_q;
  assign bus.buf_we     = buf_we_q;
  assign bus.buf_addr   = buf_addr_q;
  assign bus.buf_wdata  = buf_wdata_q;
  assign bus.cmp_req    = cmp_req_q;
  assign bus.unlock     = unlock_q;
  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_attempt_sequencer.sv
// Bench for attempt_sequencer (MAX_LEN=4, MAX_ERR=3, LOCKOUT_CYC=20,
// GRANT_CYC=10, TIMEOUT_CYC=50). A phase/queue model predicts every output
// each cycle; directed scenarios add literal expectations.
module tb_attempt_sequencer;

  localparam int MAX_LEN     = 4;
  localparam int MAX_ERR     = 3;
  localparam int LOCKOUT_CYC = 20;
  localparam int GRANT_CYC   = 10;
  localparam int TIMEOUT_CYC = 50;

  localparam int ST_IDLE    = 0;
  localparam int ST_ENTRY   = 1;
  localparam int ST_COMPARE = 2;
  localparam int ST_GRANT   = 3;
  localparam int ST_LOCKOUT = 4;

`ifdef ENTRY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  attempt_sequencer_if #(.MAX_LEN(MAX_LEN)) bus ();

  attempt_sequencer #(
    .MAX_LEN    (MAX_LEN),
    .MAX_ERR    (MAX_ERR),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .GRANT_CYC  (GRANT_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state;
  int m_q[$];        // digits held in the entry
  bit m_ovf;
  int m_err;
  int m_left;        // cycles still to spend in the current timed phase
  bit e_we, e_unlock;
  int e_addr, e_wdata;
  bit model_ready = 1'b0;

  always @(posedge clk) begin
    model_ready = 1'b1;
    e_we        = 1'b0;
    e_unlock    = 1'b0;
    if (!rst) begin
      m_state = ST_IDLE; m_q.delete(); m_ovf = 1'b0; m_err = 0; m_left = 0;
      e_addr = 0; e_wdata = 0;
    end else begin
      case (m_state)
        ST_IDLE: begin
          if (bus.digit_valid && bus.digit < 10 && !bus.clear && !bus.confirm) begin
            m_q.push_back(int'(bus.digit));
            e_we = 1'b1; e_addr = 0; e_wdata = int'(bus.digit);
            m_state = ST_ENTRY; m_left = TIMEOUT_CYC;
          end
        end
        ST_ENTRY: begin
          if (bus.clear) begin
            m_q.delete(); m_ovf = 1'b0; m_state = ST_IDLE;
          end else if (bus.confirm) begin
            m_state = ST_COMPARE;
          end else if (bus.digit_valid) begin
            if (bus.digit < 10) begin
              if (m_q.size() < MAX_LEN) begin
                e_we = 1'b1; e_addr = m_q.size(); e_wdata = int'(bus.digit);
                m_q.push_back(int'(bus.digit));
              end else m_ovf = 1'b1;
            end
            m_left = TIMEOUT_CYC;
          end else if (TO_EN) begin
            m_left--;
            if (m_left == 0) begin m_q.delete(); m_ovf = 1'b0; m_state = ST_IDLE; end
          end
        end
        ST_COMPARE: begin
          if (bus.cmp_ack) begin
            if (bus.cmp_match && !m_ovf) begin
              e_unlock = 1'b1; m_err = 0; m_state = ST_GRANT; m_left = GRANT_CYC;
            end else begin
              m_err = (m_err + 1 > 15) ? 15 : m_err + 1;
              if (m_err >= MAX_ERR) begin m_state = ST_LOCKOUT; m_left = LOCKOUT_CYC; end
              else m_state = ST_IDLE;
            end
            m_q.delete(); m_ovf = 1'b0;
          end
        end
        ST_GRANT: begin
          if (bus.confirm) m_state = ST_IDLE;
          else begin
            m_left--;
            if (m_left == 0) m_state = ST_IDLE;
          end
        end
        default: begin  // lockout
          m_left--;
          if (m_left == 0) begin m_err = 0; m_state = ST_IDLE; end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare + activity monitor ----------------
  int cnt_req, cnt_unlock, cnt_unlocked, cnt_locked, cnt_we;
  int wr_addr[$];
  int wr_data[$];

  always @(posedge clk) begin
    #1;
    if (model_ready) begin
      check("buf_we",     bus.buf_we,     e_we);
      check("buf_addr",   bus.buf_addr,   e_addr);
      check("buf_wdata",  bus.buf_wdata,  e_wdata);
      check("entry_len",  bus.entry_len,  m_q.size());
      check("cmp_req",    bus.cmp_req,    m_state == ST_COMPARE);
      check("unlock",     bus.unlock,     e_unlock);
      check("unlocked",   bus.unlocked,   m_state == ST_GRANT);
      check("locked_out", bus.locked_out, m_state == ST_LOCKOUT);
      check("err_cnt",    bus.err_cnt,    m_err);
      check("state",      bus.state,      m_state);
      if (bus.cmp_req)    cnt_req++;
      if (bus.unlock)     cnt_unlock++;
      if (bus.unlocked)   cnt_unlocked++;
      if (bus.locked_out) cnt_locked++;
      if (bus.buf_we) begin
        cnt_we++;
        wr_addr.push_back(int'(bus.buf_addr));
        wr_data.push_back(int'(bus.buf_wdata));
      end
    end
  end

  // ---------------- stimulus helpers (inputs change on negedge) ----------------
  task automatic drive(input bit dv, input logic [3:0] d, input bit cf, input bit cl,
                       input bit ack, input bit mt);
    bus.digit_valid = dv; bus.digit = d; bus.confirm = cf; bus.clear = cl;
    bus.cmp_ack = ack; bus.cmp_match = mt;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    cnt_req = 0; cnt_unlock = 0; cnt_unlocked = 0; cnt_locked = 0; cnt_we = 0;
    wr_addr.delete(); wr_data.delete();
  endtask

  task automatic attempt(input logic [3:0] d, input bit mt);
    press(d);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, mt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b0;
    idle(2);
    check("rst_state", bus.state, ST_IDLE);
    check("rst_err",   bus.err_cnt, 0);
    rst = 1'b1;
    idle(1);

    // Reset in the middle of an entry of three digits.
    press(4'd1); press(4'd2); press(4'd3);
    check("pre_rst_len", bus.entry_len, 3);
    rst = 1'b0;
    idle(2);
    check("midrst_state",  bus.state, ST_IDLE);
    check("midrst_len",    bus.entry_len, 0);
    check("midrst_we",     bus.buf_we, 0);
    check("midrst_addr",   bus.buf_addr, 0);
    check("midrst_wdata",  bus.buf_wdata, 0);
    check("midrst_req",    bus.cmp_req, 0);
    check("midrst_unlckd", bus.unlocked, 0);
    check("midrst_lock",   bus.locked_out, 0);
    rst = 1'b1;
    idle(1);

    // Reset abandons a pending compare handshake.
    press(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("req_before_rst", bus.cmp_req, 1);
    rst = 1'b0;
    idle(1);
    check("req_after_rst", bus.cmp_req, 0);
    rst = 1'b1;
    idle(1);

    // Successful attempt 1,2,3 with ack four cycles after confirm.
    clear_mon();
    press(4'd1); press(4'd2); press(4'd3);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ok_unlock",   bus.unlock, 1);
    check("ok_state",    bus.state, ST_GRANT);
    idle(12);
    check("ok_req_cyc",  cnt_req, 4);
    check("ok_unlock_n", cnt_unlock, 1);
    check("ok_grant_n",  cnt_unlocked, 10);
    check("ok_we_n",     cnt_we, 3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      check("ok_wr_addr", wr_addr[i], i);
      check("ok_wr_data", wr_data[i], i + 1);
    end
    check("ok_final_st", bus.state, ST_IDLE);

    // Overflow: fifth digit is dropped and the attempt fails despite a match.
    clear_mon();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    check("ovf_len", bus.entry_len, 4);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_err",      bus.err_cnt, 1);
    check("ovf_state",    bus.state, ST_IDLE);
    check("ovf_unlock_n", cnt_unlock, 0);
    check("ovf_we_n",     cnt_we, 4);
    check("model_ovf_err", m_err, 1);
    idle(1);

    // Three mismatches -> lockout; inputs ignored for 20 cycles.
    rst = 1'b0; idle(1); rst = 1'b1; idle(1);
    clear_mon();
    attempt(4'd9, 1'b0);
    check("lk_err1", bus.err_cnt, 1);
    check("lk_st1",  bus.state, ST_IDLE);
    attempt(4'd8, 1'b0);
    check("lk_err2", bus.err_cnt, 2);
    attempt(4'd7, 1'b0);
    check("lk_err3",  bus.err_cnt, 3);
    check("lk_state", bus.state, ST_LOCKOUT);
    check("lk_flag",  bus.locked_out, 1);
    check("model_lk_err", m_err, 3);
    press(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(12);
    check("lk_still",   bus.state, ST_LOCKOUT);
    idle(4);
    check("lk_exit_st", bus.state, ST_IDLE);
    check("lk_exit_err", bus.err_cnt, 0);
    check("lk_cycles",  cnt_locked, 20);

    // Digit together with confirm: digit dropped, compare starts with len 2.
    clear_mon();
    press(4'd1); press(4'd2);
    drive(1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("dc_state", bus.state, ST_COMPARE);
    check("dc_len",   bus.entry_len, 2);
    check("dc_req",   bus.cmp_req, 1);
    check("dc_we_n",  cnt_we, 2);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("dc_err",   bus.err_cnt, 1);
    // clear together with confirm: entry discarded, no request.
    press(4'd3);
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("cc_state", bus.state, ST_IDLE);
    check("cc_len",   bus.entry_len, 0);
    check("cc_req",   bus.cmp_req, 0);
    // Non-decimal digit in IDLE and a stray ack are both ignored.
    drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bad_digit_st", bus.state, ST_IDLE);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("stray_ack_unlock", bus.unlock, 0);
    check("stray_ack_err",    bus.err_cnt, 1);

    // Grant window cut short by confirm.
    attempt(4'd4, 1'b1);
    check("early_grant", bus.unlocked, 1);
    idle(3);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("early_state",    bus.state, ST_IDLE);
    check("early_unlocked", bus.unlocked, 0);

    // Idle entry: discarded after TIMEOUT_CYC with the timer, held without it.
    attempt(4'd2, 1'b0);
    check("to_err_before", bus.err_cnt, 1);
    press(4'd6);
    idle(TIMEOUT_CYC - 1);
    check("to_not_yet", bus.state, ST_ENTRY);
    idle(1);
`ifdef ENTRY_TIMEOUT_EN
    check("to_state", bus.state, ST_IDLE);
    check("to_len",   bus.entry_len, 0);
    check("to_err",   bus.err_cnt, 1);
`else
    check("noto_state", bus.state, ST_ENTRY);
    check("noto_len",   bus.entry_len, 1);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("noto_clear", bus.state, ST_IDLE);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
